// File: rtl/sprite_dispatcher_pkg.sv
// rtl/sprite_dispatcher_pkg.sv - tile geometry constants and dispatcher state encoding
package sprite_dispatcher_pkg;

  localparam int TILE_W    = 16;
  localparam int TILE_H    = 2;
  localparam int PIX_W     = 8;
  localparam int TEX_ROW_W = TILE_W * PIX_W;
  localparam int TEX_W     = TILE_H * TEX_ROW_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH0 = 2'd1,
    FETCH1 = 2'd2,
    ISSUE  = 2'd3
  } state_t;

endpackage

// File: rtl/sprite_dispatcher.sv
// rtl/sprite_dispatcher.sv - fetches two texture rows per sprite command and broadcasts them to the tile array
module sprite_dispatcher
  import sprite_dispatcher_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int ROW_STRIDE = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_cmd_valid,
  output logic                 o_cmd_ready,
  input  logic [ADDR_W-1:0]    i_cmd_base,
  input  logic [3:0]           i_cmd_start_x,
  input  logic [7:0]           i_cmd_z,
  input  logic                 i_cmd_last,
  output logic                 o_mem_req,
  output logic [ADDR_W-1:0]    o_mem_addr,
  input  logic                 i_mem_ack,
  input  logic [TEX_ROW_W-1:0] i_mem_data,
  output logic                 o_ena,
  output logic [TEX_W-1:0]     o_texture_data,
  output logic [3:0]           o_start_x,
  output logic [7:0]           o_position_z,
  output logic                 o_tile_done,
  output logic                 o_busy
);

  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(ROW_STRIDE);

  state_t                 state, state_nxt;
  logic [ADDR_W-1:0]      base_q;
  logic [3:0]             start_x_q;
  logic [7:0]             z_q;
  logic                   last_q;
  logic [TEX_ROW_W-1:0]   row0_q;
  logic                   take_cmd, cap_row0, cap_row1;

  always_comb begin
    state_nxt   = state;
    o_cmd_ready = 1'b0;
    o_mem_req   = 1'b0;
    o_mem_addr  = '0;
    o_ena       = 1'b0;
    take_cmd    = 1'b0;
    cap_row0    = 1'b0;
    cap_row1    = 1'b0;
    case (state)
      IDLE: begin
        o_cmd_ready = 1'b1;
        if (i_cmd_valid) begin
          take_cmd  = 1'b1;
          state_nxt = FETCH0;
        end
      end
      FETCH0: begin
        o_mem_req  = 1'b1;
        o_mem_addr = base_q;
        if (i_mem_ack) begin
          cap_row0  = 1'b1;
          state_nxt = FETCH1;
        end
      end
      FETCH1: begin
        // Address wraps modulo 2^ADDR_W by the sum's width.
        o_mem_req  = 1'b1;
        o_mem_addr = base_q + STRIDE;
        if (i_mem_ack) begin
          cap_row1  = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        o_ena       = 1'b1;
        o_cmd_ready = 1'b1;
        if (i_cmd_valid) begin
          take_cmd  = 1'b1;
          state_nxt = FETCH0;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign o_busy = (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      base_q         <= '0;
      start_x_q      <= '0;
      z_q            <= '0;
      last_q         <= 1'b0;
      row0_q         <= '0;
      o_texture_data <= '0;
      o_start_x      <= '0;
      o_position_z   <= '0;
      o_tile_done    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (take_cmd) begin
        base_q    <= i_cmd_base;
        start_x_q <= i_cmd_start_x;
        z_q       <= i_cmd_z;
        last_q    <= i_cmd_last;
      end
      if (cap_row0) row0_q <= i_mem_data;
      // Broadcast registers load as the ISSUE state is entered and then hold.
      if (cap_row1) begin
        o_texture_data <= {i_mem_data, row0_q};
        o_start_x      <= start_x_q;
        o_position_z   <= z_q;
      end
      o_tile_done <= (state == ISSUE) && last_q;
    end
  end

endmodule
